muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer and HI/LO owner for the multi-cycle multiply and divide units. Accepts one MULT/DIV command at a time from the main control FSM, clears the selected unit, holds its `control` input high for a fixed cycle budget, captures the unit's Hi/Lo results into the architectural HI/LO registers, and reports completion or divide-by-zero. The main FSM stalls on `busy`; MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `MULT_CYCLES`, default 33: cycles `mult_ctrl` is held high; must be ≥ 1.
- `DIV_CYCLES`, default 35: cycles `div_ctrl` is held high; must be ≥ 1.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: command request, sampled only in IDLE.
- `op` in 1: 0 = MULT, 1 = DIV; latched with `start`.
- `mult_ctrl` out 1: control enable to the multiplier.
- `div_ctrl` out 1: control enable to the divider.
- `unit_clr` out 1: reset pulse to both units.
- `mult_hi`, `mult_lo` in 32 each: multiplier results.
- `div_hi`, `div_lo` in 32 each: divider results (remainder, quotient).
- `div_0` in 1: divider divide-by-zero flag.
- `hi`, `lo` out 32 each: architectural HI/LO.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse, new HI/LO valid.
- `div_zero` out 1: one-cycle pulse, DIV aborted.

## Operation
- States: IDLE, CLEAR, RUN, CAPTURE. All outputs are registered except `unit_clr`, `mult_ctrl`, `div_ctrl`, which decode from state and reset.
- IDLE: if `start`, latch `op` into `op_q` and go to CLEAR. Otherwise stay.
- CLEAR, one cycle: `unit_clr` = 1. Cycle counter `cnt` is set to 0. Next state is RUN.
- RUN: `mult_ctrl` = (`op_q` == 0) and `div_ctrl` = (`op_q` == 1); the other enable stays 0. `cnt` increments each cycle.
  - If `op_q` = 1 and `div_0` = 1: abort to IDLE. `div_zero` pulses next cycle. HI/LO are unchanged and `done` is not asserted.
  - Else if `cnt` == CYCLES−1 (MULT_CYCLES or DIV_CYCLES, selected by `op_q`): go to CAPTURE.
  - If `div_0` and terminal count occur together, the abort wins.
- CAPTURE, one cycle: both enables are 0. At the edge, load `hi`/`lo` from the selected unit's pair, set `done` = 1, and go to IDLE.
- `start` outside IDLE is ignored and not queued. `op` is only sampled together with `start`.
- `div_0` is ignored during MULT.
- `unit_clr` = `reset` OR (state == CLEAR).
- Reset values: state IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_zero` = 0, `cnt` = 0, enables 0.
- Reset mid-operation: the abort is immediate, no capture occurs, and `unit_clr` is high during reset.
- `cnt` is 6 bits wide; parameters above 63 are illegal.

## Timing
- `start` sampled high at edge 0:
  - CLEAR occupies cycle 1.
  - RUN occupies cycles 2 .. N+1, where N = cycle budget.
  - CAPTURE occupies cycle N+2.
  - `done` is high and new `hi`/`lo` are visible in cycle N+3.
- Latency start→done: N+3 cycles (36 for MULT, 38 for DIV at defaults).
- `busy` rises the cycle after `start` is sampled and falls in the same cycle `done` rises.
- A new `start` is accepted in the `done` cycle. Back-to-back commands therefore have N+3 cycle spacing.
- Divide-by-zero: `div_0` seen in RUN at cycle k → `div_zero` pulse and `busy` = 0 in cycle k+1.

## Configuration
- `MULDIV_MTHI_EN` defined: adds ports `wr_hi` in 1, `wr_lo` in 1, `wr_data` in 32.
  - In IDLE, `wr_hi`/`wr_lo` load `wr_data` into `hi`/`lo` at the edge. Both may be asserted in the same cycle.
  - Writes outside IDLE are ignored.
  - In IDLE, `start` and a write in the same cycle: the write is applied and the command is also accepted.
- `MULDIV_MTHI_EN` undefined: these ports are absent and HI/LO change only on capture or reset.

## Test plan
- Reset → `hi` = `lo` = 0, `busy` = 0, `unit_clr` = 1 during reset.
- MULT: `start`, `op` = 0 with bench model `mult_hi` = 0xFFFFFFFF, `mult_lo` = 0xFFFFFFEB (7 × −3) → `mult_ctrl` high exactly 33 cycles, `done` in cycle 36, `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
- DIV: 100 / 7 with `div_hi` = 2, `div_lo` = 14 → `div_ctrl` high 35 cycles, `done` in cycle 38, `hi` = 2, `lo` = 14; `mult_ctrl` stays 0.
- DIV with `div_0` asserted in the 3rd RUN cycle → `div_zero` pulse next cycle, no `done`, HI/LO keep their prior values, `busy` low.
- `start` pulsed while busy, and reset asserted in RUN cycle 10 → second command ignored; after reset state is IDLE, `hi` = `lo` = 0, no `done`.
- With `MULDIV_MTHI_EN`: `wr_hi` with 0xDEADBEEF in IDLE → `hi` = 0xDEADBEEF next cycle; the same write during RUN → `hi` unchanged.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: owns architectural HI/LO and steps one MULT/DIV command at a time.
// Optional MULDIV_MTHI_EN adds direct HI/LO write ports (MTHI/MTLO), honoured only while idle.
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 33,
    parameter int DIV_CYCLES  = 35
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    output logic        mult_ctrl,
    output logic        div_ctrl,
    output logic        unit_clr,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        div_0,
`ifdef MULDIV_MTHI_EN
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        CAPTURE
    } state_t;

    localparam logic [5:0] MULT_LAST = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LAST  = 6'(DIV_CYCLES - 1);

    state_t     state;
    logic       op_q;
    logic [5:0] cnt;
    logic [5:0] last_cnt;

    assign last_cnt = op_q ? DIV_LAST : MULT_LAST;

    // NOTE: unit enables decode straight from state and reset so they drop in the same cycle reset rises.
    assign unit_clr  = reset || (state == CLEAR);
    assign mult_ctrl = !reset && (state == RUN) && !op_q;
    assign div_ctrl  = !reset && (state == RUN) && op_q;

    // NOTE: all state here updates with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= 1'b0;
            cnt      <= 6'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
`ifdef MULDIV_MTHI_EN
                    if (wr_hi) hi <= wr_data;
                    if (wr_lo) lo <= wr_data;
`endif
                    if (start) begin
                        op_q  <= op;
                        busy  <= 1'b1;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt   <= 6'd0;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 6'd1;
                    // A divide-by-zero abort takes priority over reaching the terminal count.
                    if (op_q && div_0) begin
                        busy     <= 1'b0;
                        div_zero <= 1'b1;
                        state    <= IDLE;
                    end else if (cnt == last_cnt) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    hi    <= op_q ? div_hi : mult_hi;
                    lo    <= op_q ? div_lo : mult_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: timing of MULT/DIV, divide-by-zero abort, reset abort, optional HI/LO writes.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, op;
    logic        mult_ctrl, div_ctrl, unit_clr;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
    logic        div_0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;
`ifdef MULDIV_MTHI_EN
    logic        wr_hi, wr_lo;
    logic [31:0] wr_data;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    muldiv_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .mult_ctrl(mult_ctrl),
        .div_ctrl (div_ctrl),
        .unit_clr (unit_clr),
        .mult_hi  (mult_hi),
        .mult_lo  (mult_lo),
        .div_hi   (div_hi),
        .div_lo   (div_lo),
        .div_0    (div_0),
`ifdef MULDIV_MTHI_EN
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .wr_data  (wr_data),
`endif
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 1 (CLEAR); returns the cycle in which done rose (-1 on timeout) and enable counts.
    task automatic run_to_done(output int done_cyc, output int mc, output int dc);
        done_cyc = -1;
        mc = 0;
        dc = 0;
        for (int c = 2; c <= 80; c++) begin
            tick();
            if (mult_ctrl) mc++;
            if (div_ctrl) dc++;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    int done_cyc, mc, dc;
    int stray;

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; div_0 = 1'b0;
        mult_hi = 32'd0; mult_lo = 32'd0; div_hi = 32'd0; div_lo = 32'd0;
`ifdef MULDIV_MTHI_EN
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = 32'd0;
`endif
        tick();
        tick();
        check("rst_unit_clr", 32'(unit_clr), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mult_ctrl", 32'(mult_ctrl), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_unit_clr", 32'(unit_clr), 32'd0);

        // MULT 7 x -3, with div_0 held high to show it is ignored during MULT.
        mult_hi = 32'hFFFF_FFFF; mult_lo = 32'hFFFF_FFEB;
        div_0 = 1'b1;
        op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("mult_clear_busy", 32'(busy), 32'd1);
        check("mult_clear_unit_clr", 32'(unit_clr), 32'd1);
        check("mult_clear_ctrl", 32'(mult_ctrl), 32'd0);
        run_to_done(done_cyc, mc, dc);
        div_0 = 1'b0;
        check("mult_done_cycle", 32'(done_cyc), 32'd36);
        check("mult_ctrl_cycles", 32'(mc), 32'd33);
        check("mult_div_ctrl_cycles", 32'(dc), 32'd0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        check("mult_done_busy", 32'(busy), 32'd0);
        check("mult_div_zero", 32'(div_zero), 32'd0);

        // Back-to-back: DIV 100 / 7 issued in the done cycle.
        div_hi = 32'd2; div_lo = 32'd14;
        op = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("div_b2b_busy", 32'(busy), 32'd1);
        check("div_b2b_done_pulse", 32'(done), 32'd0);
        run_to_done(done_cyc, mc, dc);
        check("div_done_cycle", 32'(done_cyc), 32'd38);
        check("div_ctrl_cycles", 32'(dc), 32'd35);
        check("div_mult_ctrl_cycles", 32'(mc), 32'd0);
        check("div_hi", hi, 32'd2);
        check("div_lo", lo, 32'd14);
        tick();
        check("div_done_one_cycle", 32'(done), 32'd0);

        // DIV with div_0 in the 3rd RUN cycle (cycle 4): abort, HI/LO untouched.
        div_hi = 32'h1111_1111; div_lo = 32'h2222_2222;
        op = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("dz_run3_div_ctrl", 32'(div_ctrl), 32'd1);
        div_0 = 1'b1;
        tick();
        div_0 = 1'b0;
        check("dz_pulse", 32'(div_zero), 32'd1);
        check("dz_busy", 32'(busy), 32'd0);
        check("dz_done", 32'(done), 32'd0);
        check("dz_div_ctrl", 32'(div_ctrl), 32'd0);
        check("dz_hi", hi, 32'd2);
        check("dz_lo", lo, 32'd14);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || div_zero || busy) stray++;
        end
        check("dz_quiet_after", 32'(stray), 32'd0);

        // div_0 coinciding with terminal count (cycle 36 = RUN cycle 35): abort wins.
        op = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 35; i++) tick();
        check("dz_term_div_ctrl", 32'(div_ctrl), 32'd1);
        div_0 = 1'b1;
        tick();
        div_0 = 1'b0;
        check("dz_term_pulse", 32'(div_zero), 32'd1);
        check("dz_term_busy", 32'(busy), 32'd0);
        tick();
        check("dz_term_no_done", 32'(done), 32'd0);
        check("dz_term_hi", hi, 32'd2);

        // MULT; a DIV start in cycle 3 is ignored; reset in RUN cycle 10 (cycle 11).
        mult_hi = 32'hAAAA_AAAA; mult_lo = 32'h5555_5555;
        op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        op = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; op = 1'b0;
        stray = 0;
        for (int c = 4; c <= 10; c++) begin
            if (div_ctrl || !mult_ctrl) stray++;
            tick();
        end
        check("ign_start_enables", 32'(stray), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_unit_clr", 32'(unit_clr), 32'd1);
        check("midrst_mult_ctrl", 32'(mult_ctrl), 32'd0);
        tick();
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy || mult_ctrl || div_ctrl) stray++;
        end
        check("midrst_idle_after", 32'(stray), 32'd0);

`ifdef MULDIV_MTHI_EN
        wr_data = 32'hDEAD_BEEF; wr_hi = 1'b1;
        tick();
        wr_hi = 1'b0;
        check("mthi_idle_hi", hi, 32'hDEAD_BEEF);
        check("mthi_idle_lo", lo, 32'd0);
        mult_hi = 32'h0000_0001; mult_lo = 32'h0000_0002;
        wr_data = 32'h1234_5678; wr_lo = 1'b1; op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; wr_lo = 1'b0;
        check("mtlo_with_start_lo", lo, 32'h1234_5678);
        check("mtlo_with_start_busy", 32'(busy), 32'd1);
        tick();
        wr_data = 32'hCAFE_F00D; wr_hi = 1'b1; wr_lo = 1'b1;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("mthi_run_hi", hi, 32'hDEAD_BEEF);
        check("mthi_run_lo", lo, 32'h1234_5678);
        for (int i = 0; i < 60 && !done; i++) tick();
        check("mthi_capture_hi", hi, 32'h0000_0001);
        check("mthi_capture_done", 32'(done), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
